hilo_div: RTL

HILO_DIV -- requirements
Module: hilo_div

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/twos_neg.sv | 14 +
 rtl/hilo_div.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: FSM encoding and sizing.
package mdu_pkg;

  // Default operand/result width of the MDU datapath.
  localparam int MDU_WIDTH = 32;

  // Sequencer states shared by the divider and the multiplier/HI-LO unit.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  // Step counter width: enough to count 0..w-1 with one spare bit.
  function automatic int mdu_cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/twos_neg.sv
// Conditional two's-complement negate; used for operand magnitudes and
// for applying the result signs.
module twos_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  // Pass through, or return the two's-complement negation.
  assign o_val = i_neg ? (-i_val) : i_val;

endmodule

// File: rtl/hilo_div.sv
// MIPS div/divu unit: radix-2 restoring divider, one quotient bit per cycle,
// results delivered into the HI (remainder) and LO (quotient) registers.
module hilo_div
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W = mdu_cnt_width(WIDTH);

  mdu_state_e       r_state;
  logic [WIDTH-1:0] r_a;          // captured dividend, needed for hi on /0
  logic [WIDTH-1:0] r_bmag;       // divisor magnitude
  logic [WIDTH:0]   r_rem;        // partial remainder
  logic [WIDTH-1:0] r_quot;       // dividend magnitude shifting out, quotient shifting in
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz_pend;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dbz;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH+1:0] w_rem_shift;
  logic [WIDTH+1:0] w_rem_diff;
  logic             w_qbit;
  logic [WIDTH:0]   w_rem_next;

  // Operand magnitudes taken straight from the inputs at the capture edge.
  twos_neg #(.WIDTH(WIDTH)) u_neg_a (
    .i_val(a), .i_neg(is_signed & a[WIDTH-1]), .o_val(w_a_mag)
  );
  twos_neg #(.WIDTH(WIDTH)) u_neg_b (
    .i_val(b), .i_neg(is_signed & b[WIDTH-1]), .o_val(w_b_mag)
  );

  // Result sign correction applied during FIX.
  twos_neg #(.WIDTH(WIDTH)) u_neg_q (
    .i_val(r_quot), .i_neg(r_neg_q), .o_val(w_quot_fix)
  );
  twos_neg #(.WIDTH(WIDTH)) u_neg_r (
    .i_val(r_rem[WIDTH-1:0]), .i_neg(r_neg_r), .o_val(w_rem_fix)
  );

  // One restoring step: shift in the next dividend bit, trial-subtract the
  // divisor, keep the difference only if it did not go negative.
  assign w_rem_shift = {r_rem, r_quot[WIDTH-1]};
  assign w_rem_diff  = w_rem_shift - {2'b00, r_bmag};
  assign w_qbit      = ~w_rem_diff[WIDTH+1];
  assign w_rem_next  = w_qbit ? w_rem_diff[WIDTH:0] : w_rem_shift[WIDTH:0];

  // Sequencer and datapath registers; HI/LO are only ever written in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_a        <= '0;
      r_bmag     <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_dbz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a        <= a;
            r_bmag     <= w_b_mag;
            r_quot     <= w_a_mag;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_neg_q    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r    <= is_signed & a[WIDTH-1];
            r_dbz_pend <= (b == '0);
            r_busy     <= (b != '0);
            r_state    <= (b == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          r_rem  <= w_rem_next;
          r_quot <= {r_quot[WIDTH-2:0], w_qbit};
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_quot  <= w_quot_fix;
          r_rem   <= {1'b0, w_rem_fix};
          r_busy  <= 1'b0;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_dbz   <= r_dbz_pend;
          if (r_dbz_pend) begin
            r_hi <= r_a;
            r_lo <= '1;
          end else begin
            r_hi <= r_rem[WIDTH-1:0];
            r_lo <= r_quot;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule
